// File: rtl/map_camera_controller.sv
// Level camera sequencer: detects level-boundary crossings of the player and runs a
// frame-synchronous slide (offset up, commit level, offset down), plus forced level loads.
module map_camera_controller #(
    parameter int PHY_WIDTH    = 16,
    parameter int CAMERA_WIDTH = 6,
    parameter int LEVEL_HEIGHT = 480,
    parameter int NUM_LEVELS   = 32,
    parameter int OFFSET_MAX   = 32,
    parameter int SCROLL_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic [PHY_WIDTH-1:0]    player_y,
    input  logic                    load_valid,
    input  logic [CAMERA_WIDTH-1:0] load_level,
    output logic [CAMERA_WIDTH-1:0] camera_y,
    output logic [CAMERA_WIDTH-1:0] camera_offset,
    output logic                    busy,
    output logic                    level_change
);

    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

    localparam logic [CAMERA_WIDTH-1:0] LAST_LVL  = CAMERA_WIDTH'(NUM_LEVELS - 1);
    localparam logic [PHY_WIDTH:0]      LH_WIDE   = (PHY_WIDTH + 1)'(LEVEL_HEIGHT);
    localparam logic [PHY_WIDTH-1:0]    LH        = PHY_WIDTH'(LEVEL_HEIGHT);
    localparam logic [31:0]             STEP32    = 32'(SCROLL_STEP);
    localparam logic [31:0]             MAX32     = 32'(OFFSET_MAX);
    localparam logic [CAMERA_WIDTH-1:0] OFF_MAX   = CAMERA_WIDTH'(OFFSET_MAX);
    localparam logic [CAMERA_WIDTH-1:0] OFF_FIRST =
        CAMERA_WIDTH'((SCROLL_STEP < OFFSET_MAX) ? SCROLL_STEP : OFFSET_MAX);

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_i_n = rst_sync[1];

    state_t                  state, state_nxt;
    logic                    dir, dir_nxt;              // 1 = moving up a level
    logic [PHY_WIDTH-1:0]    base, base_nxt;            // camera_y * LEVEL_HEIGHT
    logic [CAMERA_WIDTH-1:0] cam_nxt, off_nxt;
    logic                    lc_nxt;
    logic                    pending_load;
    logic [CAMERA_WIDTH-1:0] pending_level;

    logic                    load_now;
    logic [CAMERA_WIDTH-1:0] load_src, load_lvl;
    logic                    up_cross, down_cross, at_peak;
    logic [31:0]             off32, rise_sum;
    logic [CAMERA_WIDTH-1:0] rise_off, fall_off;

    // A load arriving on the tick itself is applied on that tick.
    assign load_now = frame_tick && (pending_load || load_valid);
    assign load_src = load_valid ? load_level : pending_level;
    assign load_lvl = (load_src > LAST_LVL) ? LAST_LVL : load_src;

    assign up_cross   = ({1'b0, player_y} >= ({1'b0, base} + LH_WIDE)) && (camera_y < LAST_LVL);
    assign down_cross = (player_y < base) && (camera_y != '0);

    assign off32    = 32'(camera_offset);
    assign rise_sum = off32 + STEP32;
    assign rise_off = CAMERA_WIDTH'((rise_sum > MAX32) ? MAX32 : rise_sum);
    assign fall_off = CAMERA_WIDTH'((off32 > STEP32) ? (off32 - STEP32) : 32'd0);
    assign at_peak  = (camera_offset == OFF_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (frame_tick) begin
            if (load_now) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE:    if (up_cross || down_cross) state_nxt = RISE;
                    RISE:    if (at_peak) state_nxt = FALL;
                    FALL:    if (fall_off == '0) state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        cam_nxt  = camera_y;
        off_nxt  = camera_offset;
        base_nxt = base;
        dir_nxt  = dir;
        lc_nxt   = 1'b0;
        if (frame_tick) begin
            if (load_now) begin
                cam_nxt  = load_lvl;
                base_nxt = PHY_WIDTH'(32'(load_lvl) * 32'(LEVEL_HEIGHT));
                off_nxt  = '0;
                lc_nxt   = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (up_cross || down_cross) begin
                            dir_nxt = up_cross;
                            off_nxt = OFF_FIRST;
                        end
                    end
                    RISE: begin
                        if (at_peak) begin
                            cam_nxt  = dir ? (camera_y + 1'b1) : (camera_y - 1'b1);
                            base_nxt = dir ? (base + LH) : (base - LH);
                            lc_nxt   = 1'b1;
                        end else begin
                            off_nxt = rise_off;
                        end
                    end
                    FALL:    off_nxt = fall_off;
                    default: off_nxt = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            camera_y      <= '0;
            camera_offset <= '0;
            base          <= '0;
            dir           <= 1'b0;
            level_change  <= 1'b0;
        end else begin
            camera_y      <= cam_nxt;
            camera_offset <= off_nxt;
            base          <= base_nxt;
            dir           <= dir_nxt;
            level_change  <= lc_nxt;
        end
    end

    // Any tick consumes the pending request, since a pending load always applies on it.
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            pending_load  <= 1'b0;
            pending_level <= '0;
        end else begin
            if (frame_tick)      pending_load <= 1'b0;
            else if (load_valid) pending_load <= 1'b1;
            if (load_valid)      pending_level <= load_level;
        end
    end

endmodule
